// File: rtl/wb_cmd_master.sv
// Byte-stream command master: parses {we, adr} commands (plus 4 write bytes),
// runs one Wishbone classic cycle with an ack timeout, and streams back status/read data.
module wb_cmd_master #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  output logic        wb_we_o,
  output logic [6:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [7:0] TmoLast = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWdata, StBus, StResp} state_e;

  state_e      state_q;
  logic        cmd_we_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  tmo_cnt_q;
  logic [2:0]  tx_idx_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cmd_we_q   <= 1'b0;
      byte_cnt_q <= 2'd0;
      tmo_cnt_q  <= 8'd0;
      tx_idx_q   <= 3'd0;
      rdata_q    <= 32'd0;
      rx_ready   <= 1'b0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 7'd0;
      wb_dat_o   <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          rx_ready <= 1'b1;
          if (rx_valid && rx_ready) begin
            cmd_we_q   <= rx_data[7];
            wb_adr_o   <= rx_data[6:0];
            byte_cnt_q <= 2'd0;
            if (rx_data[7]) begin
              state_q <= StWdata;
            end else begin
              state_q   <= StBus;
              rx_ready  <= 1'b0;
              wb_stb_o  <= 1'b1;
              wb_cyc_o  <= 1'b1;
              wb_we_o   <= 1'b0;
              tmo_cnt_q <= 8'd0;
            end
          end
        end
        StWdata: begin
          if (rx_valid && rx_ready) begin
            wb_dat_o[{byte_cnt_q, 3'b000} +: 8] <= rx_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q   <= StBus;
              rx_ready  <= 1'b0;
              wb_stb_o  <= 1'b1;
              wb_cyc_o  <= 1'b1;
              wb_we_o   <= 1'b1;
              tmo_cnt_q <= 8'd0;
            end
          end
        end
        StBus: begin
          // Ack wins over timeout, including on the final allowed cycle.
          if (wb_ack_i || (tmo_cnt_q == TmoLast)) begin
            state_q  <= StResp;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            tx_valid <= 1'b1;
            tx_idx_q <= 3'd0;
            tx_data  <= wb_ack_i ? 8'h00 : 8'h01;
            rdata_q  <= (wb_ack_i && !cmd_we_q) ? wb_dat_i : 32'd0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (tx_ready) begin
            if (cmd_we_q || (tx_idx_q == 3'd4)) begin
              state_q  <= StIdle;
              tx_valid <= 1'b0;
              tx_data  <= 8'd0;
              rx_ready <= 1'b1;
            end else begin
              tx_data  <= rdata_q[{tx_idx_q[1:0], 3'b000} +: 8];
              tx_idx_q <= tx_idx_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
